// File: rtl/cwc_capture_ctrl.sv
// cwc_capture_ctrl: capture sequencer for the ChipWatcher sample RAM with masked Nth-match trigger and pre-trigger window
module cwc_capture_ctrl #(
  parameter int DATA_W = 51,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [ADDR_W:0]   pre_len,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [CNT_W-1:0]  trig_count,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [2:0]        state,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);
  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;
  localparam logic [ADDR_W-1:0] MAX_L = ADDR_W'(DEPTH - 1);
  state_t state_q, state_d;
  logic [DATA_W-1:0] din_q, mask_q, value_q, wdata_q;
  logic [ADDR_W-1:0] pre_q, wr_ptr_q, cnt_q, trig_q, start_q, waddr_q, raddr_q;
  logic [CNT_W-1:0]  tcnt_q, occ_q;
  logic              we_q, done_q;
  logic [ADDR_W-1:0] pre_in;
  logic              match, cap, arm_ok, fire;
  assign pre_in = pre_len[ADDR_W] ? MAX_L : pre_len[ADDR_W-1:0];
  assign match  = ((din_q ^ value_q) & mask_q) == '0;
  assign cap    = state_q inside {PRE, WAIT, POST};
  assign arm_ok = arm && (state_q == IDLE || state_q == DONE);
  assign fire   = state_q == WAIT && (force_trig || (match && occ_q == tcnt_q - 1'b1));
  // Next state: abort beats arm, arm is only honoured when no capture is running
  always_comb begin
    state_d = state_q;
    if (abort) state_d = IDLE;
    else if (arm_ok) state_d = pre_in != '0 ? PRE : WAIT;
    else
      case (state_q)
        PRE:     state_d = cnt_q == pre_q - 1'b1 ? WAIT : PRE;
        WAIT:    state_d = fire ? (pre_q == MAX_L ? DONE : POST) : WAIT;
        POST:    state_d = cnt_q == ADDR_W'(1) ? DONE : POST;
        default: state_d = state_q;
      endcase
  end
  // Datapath: input staging, config latch, ring writes, counters and readout address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      din_q    <= '0;
      mask_q   <= '0;
      value_q  <= '0;
      wdata_q  <= '0;
      pre_q    <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      trig_q   <= '0;
      start_q  <= '0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      tcnt_q   <= '0;
      occ_q    <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din;
      we_q    <= cap && !abort;
      done_q  <= state_d == DONE;
      raddr_q <= state_q == DONE ? start_q + rd_idx : rd_idx;
      if (cap && !abort) begin
        waddr_q  <= wr_ptr_q;
        wdata_q  <= din_q;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (arm_ok && !abort) begin
        mask_q   <= trig_mask;
        value_q  <= trig_value;
        tcnt_q   <= trig_count == '0 ? CNT_W'(1) : trig_count;
        pre_q    <= pre_in;
        wr_ptr_q <= '0;
        occ_q    <= '0;
        cnt_q    <= '0;
      end
      if (state_q == PRE) cnt_q <= cnt_q + 1'b1;
      if (state_q == POST) cnt_q <= cnt_q - 1'b1;
      if (state_q == WAIT && match) occ_q <= occ_q + 1'b1;
      if (fire) begin
        trig_q <= wr_ptr_q;
        cnt_q  <= MAX_L - pre_q;
      end
      if (state_d == DONE && state_q != DONE) start_q <= (fire ? wr_ptr_q : trig_q) - pre_q;
    end
  end
  assign ram_we     = we_q;
  assign ram_waddr  = waddr_q;
  assign ram_wdata  = wdata_q;
  assign ram_raddr  = raddr_q;
  assign state      = state_q;
  assign done       = done_q;
  assign trig_addr  = trig_q;
  assign start_addr = start_q;
endmodule
